// File: rtl/frame_read_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_read_if                                             |
// | Purpose  : Avalon-style burst read master bundle for frame_read.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface frame_read_if;
   logic [31:0] avl_m0_address;
   logic        avl_m0_read;
   logic        avl_m0_begin_burst_transfer;
   logic [7:0]  avl_m0_burst_count;
   logic        avl_m0_request_ready;
   logic        avl_m0_resp_valid;
   logic [31:0] avl_m0_resp_data;
   logic        avl_m0_resp_ready;
   logic        avl_m0_write;

   modport master (
      output avl_m0_address, avl_m0_read, avl_m0_begin_burst_transfer,
             avl_m0_burst_count, avl_m0_resp_ready, avl_m0_write,
      input  avl_m0_request_ready, avl_m0_resp_valid, avl_m0_resp_data
   );

   modport slave (
      input  avl_m0_address, avl_m0_read, avl_m0_begin_burst_transfer,
             avl_m0_burst_count, avl_m0_resp_ready, avl_m0_write,
      output avl_m0_request_ready, avl_m0_resp_valid, avl_m0_resp_data
   );
endinterface
`default_nettype wire

// File: rtl/frame_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : frame_read                                                |
// | Purpose  : Streams the displayed frame from SDRAM in bursts into a   |
// |            word FIFO and hands out 16-bit pixels on request.         |
// |            Optional: FRAME_READ_UNDERFLOW_CNT_EN adds underflow_cnt. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module frame_read #(
   parameter int FIFO_DEPTH  = 1024,
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 393216
) (
   input  wire logic        clk,
   input  wire logic        rest,
   input  wire logic        frame_start,
   input  wire logic [1:0]  disp_block_num,
   output logic      [1:0]  read_block_num,
   frame_read_if.master     avl,
   input  wire logic        pix_req,
   output logic      [15:0] pix_data,
   output logic             underflow
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
   ,
   output logic      [15:0] underflow_cnt
`endif
);

   localparam int c_AW         = $clog2(FIFO_DEPTH);
   localparam int c_CW         = c_AW + 1;
   localparam int c_BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int c_LAST_INT   = BURST_LEN - 1;
   localparam int c_FINAL_INT  = FRAME_WORDS - BURST_LEN;
   localparam logic [c_CW-1:0] c_DEPTH      = FIFO_DEPTH[c_CW-1:0];
   localparam logic [c_CW-1:0] c_BURST_CW   = BURST_LEN[c_CW-1:0];
   localparam logic [18:0]     c_BURST_W    = BURST_LEN[18:0];
   localparam logic [18:0]     c_FINAL_W    = c_FINAL_INT[18:0];
   localparam logic [c_BW-1:0] c_LAST_BEAT  = c_LAST_INT[c_BW-1:0];
   localparam logic [7:0]      c_BURST_CNT  = c_LAST_INT[7:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RECV  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_frame_active, r_done;
   logic [1:0]        r_block;
   logic [18:0]       r_word_cnt;
   logic [c_BW-1:0]   r_beat_cnt;
   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic              r_half;
   logic [15:0]       r_pix_data;
   logic              r_underflow;
   logic              w_read;

   wire logic        w_beat      = avl.avl_m0_resp_valid &&
                                   (r_state == ST_RECV || r_state == ST_DRAIN);
   wire logic        w_last_beat = w_beat && (r_beat_cnt == c_LAST_BEAT);
   wire logic        w_push      = avl.avl_m0_resp_valid && (r_state == ST_RECV) && !frame_start;
   wire logic        w_empty     = (r_count == '0);
   wire logic        w_pop       = pix_req && !frame_start && !w_empty && r_half;
   wire logic [c_CW-1:0] w_free  = c_DEPTH - r_count;
   wire logic [31:0] w_head      = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rest) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_read      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_frame_active && !r_done && (w_free >= c_BURST_CW))
               w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            w_read = 1'b1;
            if (avl.avl_m0_request_ready)
               w_state_nxt = frame_start ? ST_DRAIN : ST_RECV;
            else if (frame_start)
               w_state_nxt = ST_IDLE;
         end
         ST_RECV: begin
            // A last beat coinciding with frame_start completes the burst; nothing left to drain.
            if (w_last_beat)      w_state_nxt = ST_IDLE;
            else if (frame_start) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_last_beat) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         r_frame_active <= 1'b0;
         r_done         <= 1'b0;
         r_block        <= 2'd0;
         r_word_cnt     <= '0;
         r_beat_cnt     <= '0;
      end else begin
         if (r_state == ST_REQ) r_beat_cnt <= '0;
         else if (w_beat)       r_beat_cnt <= r_beat_cnt + c_BW'(1);

         if (frame_start) begin
            r_frame_active <= 1'b1;
            r_done         <= 1'b0;
            r_block        <= disp_block_num;
            r_word_cnt     <= '0;
         end else if (w_last_beat && r_state == ST_RECV) begin
            r_word_cnt <= r_word_cnt + c_BURST_W;
            // word_cnt may wrap at 2^19, so frame end is tracked separately.
            if (r_word_cnt == c_FINAL_W) r_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= avl.avl_m0_resp_data;
   end

   always_ff @(posedge clk) begin
      if (rest || frame_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + c_CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - c_CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         r_half      <= 1'b0;
         r_pix_data  <= 16'h0000;
         r_underflow <= 1'b0;
      end else if (frame_start) begin
         r_half      <= 1'b0;
         r_underflow <= 1'b0;
         if (pix_req) r_pix_data <= 16'h0000;
      end else if (pix_req) begin
         if (!w_empty) begin
            r_pix_data <= r_half ? w_head[31:16] : w_head[15:0];
            r_half     <= ~r_half;
         end else begin
            r_pix_data  <= 16'h0000;
            r_underflow <= 1'b1;
         end
      end
   end

`ifdef FRAME_READ_UNDERFLOW_CNT_EN
   logic [15:0] r_ucnt;
   always_ff @(posedge clk) begin
      if (rest || frame_start)
         r_ucnt <= 16'h0000;
      else if (pix_req && w_empty && r_ucnt != 16'hFFFF)
         r_ucnt <= r_ucnt + 16'd1;
   end
   assign underflow_cnt = r_ucnt;
`endif

   assign read_block_num                  = r_block;
   assign pix_data                        = r_pix_data;
   assign underflow                       = r_underflow;
   assign avl.avl_m0_address              = {9'd0, r_block, r_word_cnt, 2'd0};
   assign avl.avl_m0_read                 = w_read;
   assign avl.avl_m0_begin_burst_transfer = w_read;
   assign avl.avl_m0_burst_count          = c_BURST_CNT;
   assign avl.avl_m0_resp_ready           = 1'b1;
   assign avl.avl_m0_write                = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_frame_read.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_frame_read                                             |
// | Purpose  : Scoreboard bench for frame_read (default and 512-word     |
// |            frame instances).                                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_frame_read;
   localparam int c_BL = 256;

   logic       clk = 1'b0;
   logic       rest = 1'b1;
   logic       frame_start = 1'b0;
   logic       pix_req = 1'b0;
   logic [1:0] disp_block_num = 2'd0;

   always #5 clk = ~clk;

   frame_read_if bus1 ();
   frame_read_if bus2 ();

   logic [1:0]  rbn1, rbn2;
   logic [15:0] pix1, pix2;
   logic        uf1, uf2;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
   logic [15:0] ucnt1, ucnt2;
`endif

   frame_read dut1 (
      .clk(clk), .rest(rest), .frame_start(frame_start), .disp_block_num(disp_block_num),
      .read_block_num(rbn1), .avl(bus1), .pix_req(pix_req), .pix_data(pix1), .underflow(uf1)
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      , .underflow_cnt(ucnt1)
`endif
   );

   frame_read #(.FRAME_WORDS(512)) dut2 (
      .clk(clk), .rest(rest), .frame_start(frame_start), .disp_block_num(disp_block_num),
      .read_block_num(rbn2), .avl(bus2), .pix_req(pix_req), .pix_data(pix2), .underflow(uf2)
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      , .underflow_cnt(ucnt2)
`endif
   );

   int compared = 0;
   int mismatched = 0;
   logic [31:0] exp_addr [$];
   logic [15:0] exp_pix  [$];
   int req1 = 0, req2 = 0, burst_beats1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input logic [1:0] b, input logic [18:0] w);
      logic [15:0] off;
      off = {6'd0, b ^ 2'd2, 8'd0};
      return {16'h1234 + w[15:0] + off, 16'h5678 + w[15:0] + off};
   endfunction

   // Slave for dut1: one beat per cycle, data derived from the word address.
   initial begin : slave1
      int left;
      logic [18:0] widx;
      logic [1:0] blk;
      left = 0; widx = '0; blk = '0;
      bus1.avl_m0_resp_valid = 1'b0;
      bus1.avl_m0_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (left > 0) begin
            bus1.avl_m0_resp_valid = 1'b1;
            bus1.avl_m0_resp_data  = word_of(blk, widx);
            widx = widx + 19'd1;
            left--;
            burst_beats1++;
         end else begin
            bus1.avl_m0_resp_valid = 1'b0;
         end
         if (bus1.avl_m0_read && bus1.avl_m0_request_ready) begin
            left = c_BL;
            widx = bus1.avl_m0_address[20:2];
            blk  = bus1.avl_m0_address[22:21];
            burst_beats1 = 0;
            req1++;
         end
      end
   end

   initial begin : slave2
      int left;
      left = 0;
      bus2.avl_m0_resp_valid = 1'b0;
      bus2.avl_m0_resp_data  = '0;
      forever begin
         @(negedge clk);
         bus2.avl_m0_resp_valid = (left > 0);
         bus2.avl_m0_resp_data  = 32'(left);
         if (left > 0) left--;
         if (bus2.avl_m0_read && bus2.avl_m0_request_ready) begin
            left = c_BL;
            req2++;
         end
      end
   end

   initial begin : req_monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (bus1.avl_m0_read && bus1.avl_m0_request_ready) begin
            if (exp_addr.size() == 0) begin
               chk("unexpected_req", bus1.avl_m0_address, 32'hFFFF_FFFF);
            end else begin
               e = exp_addr.pop_front();
               chk("req_addr", bus1.avl_m0_address, e);
               chk("burst_count", 32'(bus1.avl_m0_burst_count), 32'd255);
               chk("begin_burst", 32'(bus1.avl_m0_begin_burst_transfer), 32'd1);
            end
         end
      end
   end

   initial begin : pix_monitor
      logic s;
      logic [15:0] e;
      forever begin
         @(posedge clk);
         s = pix_req;
         @(negedge clk);
         if (s) begin
            if (exp_pix.size() == 0) begin
               chk("unexpected_pix", 32'(pix1), 32'hFFFF_FFFF);
            end else begin
               e = exp_pix.pop_front();
               chk("pix_data", 32'(pix1), 32'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int prev, base2, k;
      bus1.avl_m0_request_ready = 1'b0;
      bus2.avl_m0_request_ready = 1'b0;

      // Reset
      rest = 1'b1;
      tick(3);
      chk("rst_read", 32'(bus1.avl_m0_read), 0);
      chk("rst_begin", 32'(bus1.avl_m0_begin_burst_transfer), 0);
      chk("rst_pix", 32'(pix1), 0);
      chk("rst_underflow", 32'(uf1), 0);
      chk("rst_block", 32'(rbn1), 0);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      chk("rst_ucnt", 32'(ucnt1), 0);
`endif
      rest = 1'b0;
      bus1.avl_m0_request_ready = 1'b1;
      bus2.avl_m0_request_ready = 1'b1;
      tick(5);
      chk("no_req_before_frame", 32'(bus1.avl_m0_read), 0);

      // Addressing and FIFO fill: exactly four bursts into block 2
      exp_addr.push_back(32'h0040_0000);
      exp_addr.push_back(32'h0040_0400);
      exp_addr.push_back(32'h0040_0800);
      exp_addr.push_back(32'h0040_0C00);
      disp_block_num = 2'd2;
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(1200);
      chk("fill_req_count", 32'(req1), 4);
      chk("fill_read_idle", 32'(bus1.avl_m0_read), 0);
      chk("read_block_num", 32'(rbn1), 2);
      chk("frame512_req_count", 32'(req2), 2);

      // 512 pixels free one burst of space
      exp_addr.push_back(32'h0040_1000);
      for (int i = 0; i < 512; i++) begin
         pix_req = 1'b1;
         exp_pix.push_back((i % 2 == 0) ? 16'h5678 + 16'(i / 2) : 16'h1234 + 16'(i / 2));
         tick(1);
      end
      pix_req = 1'b0;
      tick(400);
      chk("fifth_req", 32'(req1), 5);
      chk("no_underflow", 32'(uf1), 0);
      chk("frame512_done", 32'(req2), 2);

      // Abort a burst after 100 beats
      exp_addr.push_back(32'h0020_0000);
      exp_addr.push_back(32'h0020_0000);
      exp_addr.push_back(32'h0020_0400);
      exp_addr.push_back(32'h0020_0800);
      exp_addr.push_back(32'h0020_0C00);
      disp_block_num = 2'd1;
      prev = req1;
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      k = 0;
      while (req1 == prev && k < 20) begin tick(1); k++; end
      chk("abort_req_issued", 32'(req1 > prev), 1);
      k = 0;
      while (burst_beats1 < 100 && k < 400) begin tick(1); k++; end
      chk("abort_beats_reached", 32'(burst_beats1 >= 100), 1);
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(50);
      pix_req = 1'b1;
      exp_pix.push_back(16'h0000);
      tick(1);
      pix_req = 1'b0;
      chk("underflow_set", 32'(uf1), 1);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      chk("ucnt_one", 32'(ucnt1), 1);
`endif
      chk("no_req_during_drain", 32'(req1), 32'(prev + 1));
      tick(1400);
      chk("post_abort_reqs", 32'(req1), 32'(prev + 5));
      chk("underflow_sticky", 32'(uf1), 1);

      // Block 1 data order, then frame_start together with pix_req
      exp_pix.push_back(16'h5978);
      exp_pix.push_back(16'h1534);
      exp_pix.push_back(16'h5979);
      exp_pix.push_back(16'h1535);
      pix_req = 1'b1;
      tick(4);
      exp_addr.push_back(32'h0060_0000);
      exp_addr.push_back(32'h0060_0400);
      exp_addr.push_back(32'h0060_0800);
      exp_addr.push_back(32'h0060_0C00);
      disp_block_num = 2'd3;
      base2 = req2;
      frame_start = 1'b1;
      exp_pix.push_back(16'h0000);
      tick(1);
      frame_start = 1'b0;
      pix_req = 1'b0;
      chk("underflow_cleared", 32'(uf1), 0);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      chk("ucnt_cleared", 32'(ucnt1), 0);
`endif
      chk("block3", 32'(rbn1), 3);
      tick(1400);
      chk("frame512_second_frame", 32'(req2 - base2), 2);
      chk("addr_queue_drained", 32'(exp_addr.size()), 0);
      chk("pix_queue_drained", 32'(exp_pix.size()), 0);
      chk("final_read_idle", 32'(bus1.avl_m0_read), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/frame_read.md
Name: frame_read

Overview:
- SDRAM-to-display reader; the read-side counterpart of the camera frame writer.
- At each display frame start, latches the displayed block number and streams that frame from SDRAM in fixed bursts over the Avalon-style master port.
- Buffers 32-bit words in an internal synchronous FIFO and hands out 16-bit pixels on request to the HDMI timing/output stage. Single clock domain.

Parameters:
- FIFO_DEPTH, 1024, internal FIFO depth in 32-bit words; power of two, ≥ 2*BURST_LEN.
- BURST_LEN, 256, words per read burst; power of two, ≤ 256.
- FRAME_WORDS, 393216, 32-bit words per frame (1024x768 RGB565); multiple of BURST_LEN, ≤ 2^19.

Ports:
- clk  in  1  system/SDRAM-controller clock; all logic on rising edge.
- rest  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse from display timing (start of vsync).
- disp_block_num  in  2  block most recently completed by the writer.
- read_block_num  out  2  block currently being read; lets the writer avoid it.
- avl_m0_address  out  32  byte address {9'd0, read_block_num, word_cnt[18:0], 2'd0}.
- avl_m0_read  out  1  read request.
- avl_m0_begin_burst_transfer  out  1  high with avl_m0_read for the burst request.
- avl_m0_burst_count  out  8  BURST_LEN-1 (beats minus one).
- avl_m0_request_ready  in  1  slave accepts the request in the cycle read && request_ready.
- avl_m0_resp_valid  in  1  read data beat valid.
- avl_m0_resp_data  in  32  read data beat.
- avl_m0_resp_ready  out  1  constant 1; FIFO space is reserved before each request.
- avl_m0_write  out  1  constant 0.
- pix_req  in  1  display consumes one pixel.
- pix_data  out  16  pixel, registered, valid the cycle after pix_req.
- underflow  out  1  sticky; pix_req seen with FIFO empty; cleared on frame_start.

Behaviour:
- Reset: state IDLE, frame inactive, read_block_num=0, word_cnt=0, FIFO empty, half-select=0, pix_data=0, underflow=0, avl_m0_read=0, avl_m0_begin_burst_transfer=0.
- frame_start (any state), same edge:
  - read_block_num <= disp_block_num; word_cnt <= 0; FIFO flushed; half-select <= 0; underflow <= 0; frame active.
- States:
  - IDLE: if frame active && word_cnt < FRAME_WORDS && FIFO free ≥ BURST_LEN → REQ. Otherwise stay.
  - REQ: assert read and begin_burst_transfer. Address is held stable.
    - On request_ready → RECV; both strobes drop next cycle.
    - frame_start with request_ready in the same cycle → DRAIN.
    - frame_start without request_ready → IDLE (request withdrawn).
  - RECV: each resp_valid writes resp_data into the FIFO and increments beat_cnt.
    - On the last beat: word_cnt += BURST_LEN → IDLE.
    - frame_start in RECV → DRAIN.
  - DRAIN: discard beats until BURST_LEN total have arrived for the aborted burst, then → IDLE. Nothing is written to the FIFO.
- At most one burst is outstanding.
- word_cnt == FRAME_WORDS: no further requests until the next frame_start.
- Pixel output: FIFO read is first-word-fall-through.
  - pix_req with FIFO non-empty: pix_data <= half-select ? word[31:16] : word[15:0]; half-select toggles.
  - The FIFO pops when the upper half is emitted.
- pix_req with FIFO empty: pix_data <= 16'h0000, underflow <= 1, half-select unchanged.
- Same-cycle FIFO write and pop are both honoured. The FIFO never overflows because space is reserved before each request.
- frame_start and pix_req in the same cycle: the flush wins; pix_data <= 0, no underflow flagged.

Optional Feature:
- FRAME_READ_UNDERFLOW_CNT_EN:
  - Defined: adds output underflow_cnt[15:0], counting empty-FIFO pix_req cycles. Saturates at 16'hFFFF, reset to 0 by rest and by frame_start.
  - Undefined: port and counter absent; only the sticky underflow flag exists.

Test Plan:
- Reset: assert rest for 3 cycles → all outputs at reset values, avl_m0_read=0, pix_data=0, underflow=0.
- Addressing: disp_block_num=2, frame_start, slave always ready → first request address 0x0040_0000 with burst_count=255; second request 0x0040_0400; read_block_num=2.
- FIFO fill: no pix_req → exactly 4 bursts (1024 words) issued, then avl_m0_read stays 0. One burst of pix_req (512 pixels) → a fifth request issues.
- Pixel order: first FIFO word 0x1234_5678, pix_req two cycles → pix_data 0x5678 then 0x1234.
- Abort: frame_start (disp_block_num=1) after 100 beats of a burst → remaining 156 beats are not stored, FIFO stays empty, next request address 0x0020_0000.
- Underflow and frame end: pix_req on an empty FIFO → pix_data=0, underflow=1 (and underflow_cnt=1 with the macro), cleared at the next frame_start. With FRAME_WORDS=512 → exactly 2 requests per frame.
